// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Behavioural data-memory responder for a pipelined core.
//               Accepts one load/store at a time and answers after a fixed
//               LATENCY. Dcache_StallReq is held high from the acceptance
//               cycle until the response cycle. Stores commit on the clock
//               edge that ends the response cycle. Loads are lane-shifted
//               and sign- or zero-extended.
// Parameters  : DEPTH_WORDS - storage depth in 32-bit words (power of two)
//               LATENCY     - cycles from acceptance to response (1..15)
// Ports       : clk, rst_n (async, active low)
//               Mem_DcacheEN/Rd/Width/Addr/Sign, EXMem_Rs2Data - request side
//               Dcache_DataRd   - load data, 0 outside a load response
//               Dcache_StallReq - stall request to pipeline control
//               Dcache_Misalign - misaligned-access pulse in response cycle
// Options     : define DMEM_RESP_MISALIGN_EN to detect misaligned half/word
//               accesses; otherwise the low address bits are forced aligned
//               and Dcache_Misalign is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Mem_DcacheEN,
  input  logic        Mem_DcacheRd,
  input  logic [1:0]  Mem_DcacheWidth,
  input  logic [31:0] Mem_DcacheAddr,
  input  logic        Mem_DcacheSign,
  input  logic [31:0] EXMem_Rs2Data,
  output logic [31:0] Dcache_DataRd,
  output logic        Dcache_StallReq,
  output logic        Dcache_Misalign
);

  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  // Storage is intentionally not reset; contents are undefined until written.
  logic [31:0] mem_array [DEPTH_WORDS];

  // --------------------------------------------------------------------------
  // Address decode (request inputs are used live, never registered)
  // --------------------------------------------------------------------------
  logic             is_byte, is_half;
  logic [1:0]       off_raw, off_eff;
  logic             misalign_w;
  logic [IDX_W-1:0] idx_w;
  logic             unused_addr;

  assign is_byte     = (Mem_DcacheWidth == 2'b00);
  assign is_half     = (Mem_DcacheWidth == 2'b01);
  assign off_raw     = Mem_DcacheAddr[1:0];
  assign idx_w       = Mem_DcacheAddr[IDX_W+1:2];
  // Bits above the word index are don't-care: accesses wrap.
  assign unused_addr = ^Mem_DcacheAddr[31:IDX_W+2];

`ifdef DMEM_RESP_MISALIGN_EN
  assign off_eff    = off_raw;
  assign misalign_w = (is_half && off_raw[0]) ||
                      (!is_byte && !is_half && (off_raw != 2'b00));
`else
  // Without detection, misaligned low bits are dropped so the access is
  // performed on the naturally aligned half/word.
  assign off_eff    = is_byte ? off_raw :
                      is_half ? {off_raw[1], 1'b0} : 2'b00;
  assign misalign_w = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Load path: select word, shift lane down, extend
  // --------------------------------------------------------------------------
  logic [31:0] rd_word, rd_shift, load_ext;

  assign rd_word  = mem_array[idx_w];
  assign rd_shift = rd_word >> {off_eff, 3'b000};

  always_comb begin
    load_ext = rd_shift;
    if (is_byte) begin
      load_ext = {{24{Mem_DcacheSign & rd_shift[7]}}, rd_shift[7:0]};
    end else if (is_half) begin
      load_ext = {{16{Mem_DcacheSign & rd_shift[15]}}, rd_shift[15:0]};
    end
  end

  // --------------------------------------------------------------------------
  // Store path: replicate right-aligned data across lanes, pick byte enables
  // --------------------------------------------------------------------------
  logic [3:0]  be_w;
  logic [31:0] wr_lanes;

  always_comb begin
    be_w     = 4'b1111;
    wr_lanes = EXMem_Rs2Data;
    if (is_byte) begin
      be_w     = 4'b0001 << off_eff;
      wr_lanes = {4{EXMem_Rs2Data[7:0]}};
    end else if (is_half) begin
      be_w     = off_eff[1] ? 4'b1100 : 4'b0011;
      wr_lanes = {2{EXMem_Rs2Data[15:0]}};
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  logic        stall_w;
  logic        we_w;
  logic [31:0] data_w;
  logic        mis_w;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall_w = 1'b0;
    we_w    = 1'b0;
    data_w  = 32'd0;
    mis_w   = 1'b0;
    case (state_q)
      IDLE: begin
        if (Mem_DcacheEN) begin
          stall_w = 1'b1;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        // A dropped enable is a pipeline flush: release the stall at once.
        if (!Mem_DcacheEN) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          stall_w = 1'b1;
          if (cnt_q == 4'd0) begin
            state_d = RESP;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        if (Mem_DcacheEN) begin
          mis_w = misalign_w;
          if (Mem_DcacheRd && !misalign_w) begin
            data_w = load_ext;
          end
          we_w = !Mem_DcacheRd && !misalign_w;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write commits on the edge that ends RESP. Reset forces IDLE
  // asynchronously, so an access aborted by reset never reaches here.
  always_ff @(posedge clk) begin
    if (we_w) begin
      for (int b = 0; b < 4; b++) begin
        if (be_w[b]) begin
          mem_array[idx_w][8*b +: 8] <= wr_lanes[8*b +: 8];
        end
      end
    end
  end

  // The stall is combinational from the live enable; mask it while in reset.
  assign Dcache_StallReq = stall_w & rst_n;
  assign Dcache_DataRd   = data_w;
  assign Dcache_Misalign = mis_w;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Self-checking bench for dmem_responder. A byte-addressed
//               reference memory predicts every response; expected responses
//               are queued at issue time and consumed by monitors.
//               Instance u_dut  : DEPTH_WORDS=1024, LATENCY=2
//               Instance u_dut_b: DEPTH_WORDS=16,   LATENCY=1
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en, rd, sign;
  logic [1:0]  width;
  logic [31:0] addr, wdata;
  logic [31:0] data_rd;
  logic        stall, mis;

  logic        en_b, rd_b, sign_b;
  logic [1:0]  width_b;
  logic [31:0] addr_b, wdata_b;
  logic [31:0] data_b;
  logic        stall_b, mis_b;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .Mem_DcacheEN(en), .Mem_DcacheRd(rd), .Mem_DcacheWidth(width),
    .Mem_DcacheAddr(addr), .Mem_DcacheSign(sign), .EXMem_Rs2Data(wdata),
    .Dcache_DataRd(data_rd), .Dcache_StallReq(stall), .Dcache_Misalign(mis)
  );

  dmem_responder #(.DEPTH_WORDS(16), .LATENCY(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .Mem_DcacheEN(en_b), .Mem_DcacheRd(rd_b), .Mem_DcacheWidth(width_b),
    .Mem_DcacheAddr(addr_b), .Mem_DcacheSign(sign_b), .EXMem_Rs2Data(wdata_b),
    .Dcache_DataRd(data_b), .Dcache_StallReq(stall_b), .Dcache_Misalign(mis_b)
  );

  typedef struct {
    logic [31:0] data;
    logic        mis;
  } resp_t;

  resp_t       exp_q [$];
  resp_t       exp_qb [$];
  resp_t       mon_e, mon_eb;
  logic [7:0]  mb [0:4095];     // byte-level reference memory (4 KiB image)
  logic [31:0] mw_b [0:15];     // word-level reference for the small instance
  logic        in_flush = 1'b0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model
  // -------------------------------------------------------------------------
  function automatic bit is_mis(input logic [31:0] a, input logic [1:0] w);
`ifdef DMEM_RESP_MISALIGN_EN
    return ((w == 2'b01) && a[0]) || (w[1] && (a[1:0] != 2'b00));
`else
    return 1'b0;
`endif
  endfunction

  function automatic int ealign(input logic [31:0] a, input logic [1:0] w);
    int x;
    x = int'(a & 32'h0000_0FFF);
    if (w == 2'b01) x = x & ~1;
    else if (w[1]) x = x & ~3;
    return x;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] w, input logic s);
    int x;
    logic [31:0] v;
    x = ealign(a, w);
    if (w == 2'b00) begin
      v = {24'd0, mb[x]};
      if (s && mb[x][7]) v = v | 32'hFFFF_FF00;
    end else if (w == 2'b01) begin
      v = {16'd0, mb[x+1], mb[x]};
      if (s && mb[x+1][7]) v = v | 32'hFFFF_0000;
    end else begin
      v = {mb[x+3], mb[x+2], mb[x+1], mb[x]};
    end
    return v;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [1:0] w, input logic [31:0] d);
    int x;
    x = ealign(a, w);
    mb[x] = d[7:0];
    if (w != 2'b00) mb[x+1] = d[15:8];
    if (w[1]) begin
      mb[x+2] = d[23:16];
      mb[x+3] = d[31:24];
    end
  endtask

  // -------------------------------------------------------------------------
  // Driver for u_dut. Entered and left at a falling edge.
  // flush: 0 = complete, 1 = drop enable in WAIT, 2 = drop enable in RESP.
  // -------------------------------------------------------------------------
  task automatic access(input logic r, input logic [1:0] w, input logic [31:0] a,
                        input logic s, input logic [31:0] d, input int flush);
    resp_t e;
    bit    m;
    int    n;
    m = is_mis(a, w);
    en = 1'b1; rd = r; width = w; addr = a; sign = s; wdata = d;
    e.data = (r && !m) ? model_load(a, w, s) : 32'd0;
    e.mis  = m;
    if (flush == 0) exp_q.push_back(e);
    n = 0;
    #1;
    while (stall === 1'b1 && n < 20) begin
      n++;
      @(negedge clk);
      if (flush == 1) begin
        en = 1'b0;
        #1;
        check("flush_wait_stall", stall, 1'b0);
        @(negedge clk);
        return;
      end
      #1;
    end
    check("stall_cycles", n, LAT);
    if (flush == 2) begin
      in_flush = 1'b1;
      en = 1'b0;
      @(negedge clk);
      in_flush = 1'b0;
      return;
    end
    if (!r && !m) model_store(a, w, d);
    @(negedge clk);
  endtask

  // Driver for u_dut_b (word accesses only); returns the two stall samples.
  task automatic access_b(input logic r, input logic [31:0] a, input logic [31:0] d,
                          output logic [1:0] pat);
    resp_t e;
    en_b = 1'b1; rd_b = r; width_b = 2'b10; addr_b = a; sign_b = 1'b0; wdata_b = d;
    e.data = r ? mw_b[a[5:2]] : 32'd0;
    e.mis  = 1'b0;
    exp_qb.push_back(e);
    #1 pat[1] = stall_b;
    @(negedge clk);
    #1 pat[0] = stall_b;
    if (!r) mw_b[a[5:2]] = d;
    @(negedge clk);
  endtask

  // -------------------------------------------------------------------------
  // Monitors: a response is a cycle with enable high and stall low.
  // -------------------------------------------------------------------------
  always @(negedge clk) begin
    #2;
    if (rst_n && en && !stall) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp: got data %h with no expected entry", data_rd);
      end else begin
        mon_e = exp_q.pop_front();
        check("resp_data", data_rd, mon_e.data);
        check("resp_misalign", mis, mon_e.mis);
      end
    end else if (!in_flush) begin
      check("idle_data", data_rd, 32'd0);
      check("idle_misalign", mis, 1'b0);
    end
  end

  always @(negedge clk) begin
    #2;
    if (rst_n && en_b && !stall_b) begin
      if (exp_qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_resp_b: got data %h with no expected entry", data_b);
      end else begin
        mon_eb = exp_qb.pop_front();
        check("resp_data_b", data_b, mon_eb.data);
      end
    end else begin
      check("idle_data_b", data_b, 32'd0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    logic [31:0] r32, a;
    logic [1:0]  p1, p2, pd;
    int          k, fl;

    rst_n = 1'b0;
    en = 1'b1; rd = 1'b1; width = 2'b10; addr = 32'h10; sign = 1'b0; wdata = 32'd0;
    en_b = 1'b0; rd_b = 1'b0; width_b = 2'b10; addr_b = 32'd0; sign_b = 1'b0; wdata_b = 32'd0;

    // Reset: enable held high, stall must stay low.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("reset_stall", stall, 1'b0);
      check("reset_data", data_rd, 32'd0);
      check("reset_misalign", mis, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // First request right after reset release, then a word load.
    access(1'b0, 2'b10, 32'h10, 1'b0, 32'hDEAD_BEEF, 0);
    access(1'b1, 2'b10, 32'h10, 1'b0, 32'd0, 0);

    // Fill bytes 0..255 with known data; upper address bits randomised.
    for (int i = 0; i < 64; i++) begin
      r32 = $urandom();
      a = (r32 & 32'hFFFF_F000) | (i * 4);
      access(1'b0, 2'b10, a, 1'b0, $urandom(), 0);
    end

    // Byte store into a zero word, signed/unsigned/word read-back.
    access(1'b0, 2'b10, 32'h10, 1'b0, 32'h0, 0);
    access(1'b0, 2'b00, 32'h13, 1'b0, 32'h80, 0);
    access(1'b1, 2'b00, 32'h13, 1'b1, 32'd0, 0);
    access(1'b1, 2'b00, 32'h13, 1'b0, 32'd0, 0);
    access(1'b1, 2'b10, 32'h10, 1'b0, 32'd0, 0);

    // Flushes: aborted load, aborted stores leave memory unchanged.
    access(1'b1, 2'b10, 32'h10, 1'b0, 32'd0, 1);
    access(1'b0, 2'b10, 32'h10, 1'b0, 32'h1111_1111, 1);
    access(1'b1, 2'b10, 32'h10, 1'b0, 32'd0, 0);
    access(1'b0, 2'b10, 32'h10, 1'b0, 32'h2222_2222, 2);
    access(1'b1, 2'b10, 32'h10, 1'b0, 32'd0, 0);

    // Wrap-around: 0x1000 aliases 0x0.
    access(1'b0, 2'b10, 32'h1000, 1'b0, 32'hCAFE_F00D, 0);
    access(1'b1, 2'b10, 32'h0, 1'b0, 32'd0, 0);

    // Half store to an odd address.
    access(1'b0, 2'b10, 32'h20, 1'b0, 32'h0, 0);
    access(1'b0, 2'b01, 32'h21, 1'b0, 32'h0000_BEEF, 0);
    access(1'b1, 2'b10, 32'h20, 1'b0, 32'd0, 0);

    // Reset in the middle of a store aborts it; first request after reset.
    en = 1'b1; rd = 1'b0; width = 2'b10; addr = 32'h40; sign = 1'b0; wdata = 32'h1234_5678;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_abort_stall", stall, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b1, 2'b10, 32'h40, 1'b0, 32'd0, 0);

    // Randomised traffic over the initialised region.
    for (int i = 0; i < 300; i++) begin
      r32 = $urandom();
      a = (r32 & 32'hFFFF_F000) | $urandom_range(0, 255);
      k = $urandom_range(0, 15);
      fl = (k == 0) ? 1 : ((k == 1) ? 2 : 0);
      access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), a,
             1'($urandom_range(0, 1)), $urandom(), fl);
    end
    en = 1'b0;

    // LATENCY=1 instance: back-to-back loads give stall 1,0,1,0.
    @(negedge clk);
    access_b(1'b0, 32'h4, 32'hA5A5_0001, pd);
    access_b(1'b0, 32'h8, 32'h5A5A_0002, pd);
    access_b(1'b1, 32'h4, 32'd0, p1);
    access_b(1'b1, 32'h8, 32'd0, p2);
    check("b2b_stall_pattern", {p1, p2}, 4'b1010);
    en_b = 1'b0;
    access_b(1'b1, 32'h48, 32'd0, pd);   // wraps to word 2 (0x8)
    en_b = 1'b0;

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    check("queue_empty_b", exp_qb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
